mio_responder: RTL and testbench

//  Memory/IO slave answering the multi-cycle CPU controller's bus requests (MemRead/MemWrite/addr).

---
 rtl/mio_responder.sv | 141 ++++++++++++++
 tb/tb_mio_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mio_responder.sv
// rtl/mio_responder.sv - memory/IO bus slave with wait states, word RAM and LED/switch/counter registers
module mio_responder #(
   parameter int          RAM_WORDS   = 1024,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] IO_BASE     = 32'hE000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        MIO_ready,
   input  logic [31:0] switches,
   output logic [31:0] led_out,
   output logic        bus_err
);

   localparam int          AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t      state;
   logic [3:0]  wait_cnt;
   logic [31:0] cap_addr;
   logic [31:0] cap_wdata;
   logic        cap_write;
   logic        cap_both;
   logic [31:0] cyc_cnt;
   logic [31:0] ram [RAM_WORDS];

   logic          req;
   logic          go_ack;
   logic          commit;
   logic [31:0]   cur_addr;
   logic [31:0]   cur_wdata;
   logic          cur_write;
   logic          cur_both;
   logic [AW-1:0] ram_idx;
   logic [31:0]   rd_val;
   logic          dec_err;
   logic          acc_err;
   logic          ram_we;
   logic          led_we;
   logic          cnt_clr;

   // Select the transfer being finished (live inputs when there are no wait states) and decode it
   always_comb begin
      req       = MemRead | MemWrite;
      go_ack    = (state == IDLE && req && WAIT_CYCLES == 0) ||
                  (state == WAIT && wait_cnt == 4'd0);
      commit    = go_ack & ~reset;
      cur_addr  = (state == IDLE) ? addr : cap_addr;
      cur_wdata = (state == IDLE) ? wdata : cap_wdata;
      cur_write = (state == IDLE) ? (MemWrite & ~MemRead) : cap_write;
      cur_both  = (state == IDLE) ? (MemWrite & MemRead) : cap_both;
      ram_idx   = cur_addr[2 +: AW];
      rd_val    = 32'd0;
      dec_err   = 1'b0;
      ram_we    = 1'b0;
      led_we    = 1'b0;
      cnt_clr   = 1'b0;
      if (cur_addr < RAM_BYTES) begin
         rd_val = ram[ram_idx];
         ram_we = cur_write;
      end else if (cur_addr[31:4] == IO_BASE[31:4]) begin
         case (cur_addr[3:2])
            2'd0: begin
               rd_val = led_out;
               led_we = cur_write;
            end
            2'd1: begin
               rd_val  = switches;
               dec_err = cur_write;
            end
            2'd2: begin
               rd_val  = cyc_cnt;
               cnt_clr = cur_write;
            end
            default: dec_err = 1'b1;
         endcase
      end else begin
         dec_err = 1'b1;
      end
      acc_err = dec_err | cur_both | (cur_addr[1:0] != 2'b00);
   end

   // Word RAM: contents survive reset; a write lands on the edge that enters ACK
   always_ff @(posedge clk) begin
      if (commit && ram_we) begin
         ram[ram_idx] <= cur_wdata;
      end
   end

   // Transfer FSM with registered completion, read data, IO registers and the cycle counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         cap_addr  <= 32'd0;
         cap_wdata <= 32'd0;
         cap_write <= 1'b0;
         cap_both  <= 1'b0;
         MIO_ready <= 1'b0;
         rdata     <= 32'd0;
         led_out   <= 32'd0;
         cyc_cnt   <= 32'd0;
         bus_err   <= 1'b0;
      end else begin
         MIO_ready <= 1'b0;
         rdata     <= 32'd0;
         cyc_cnt   <= (go_ack && cnt_clr) ? 32'd0 : cyc_cnt + 32'd1;
         if (go_ack) begin
            MIO_ready <= 1'b1;
            rdata     <= rd_val;
            if (led_we) led_out <= cur_wdata;
            if (acc_err) bus_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (req) begin
                  cap_addr  <= addr;
                  cap_wdata <= wdata;
                  cap_write <= MemWrite & ~MemRead;
                  cap_both  <= MemWrite & MemRead;
                  wait_cnt  <= 4'(WAIT_CYCLES - 1);
                  state     <= (WAIT_CYCLES == 0) ? ACK : WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt == 4'd0) state <= ACK;
               else wait_cnt <= wait_cnt - 4'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mio_responder.sv
// tb/tb_mio_responder.sv - directed self-checking bench for mio_responder
module tb_mio_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        MIO_ready;
   logic [31:0] switches = 32'd0;
   logic [31:0] led_out;
   logic        bus_err;

   int pass_cnt = 0;
   int total_cnt = 0;

   mio_responder #(.RAM_WORDS(1024), .WAIT_CYCLES(2), .IO_BASE(32'hE000_0000)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .addr(addr), .wdata(wdata), .rdata(rdata), .MIO_ready(MIO_ready),
      .switches(switches), .led_out(led_out), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Drives one request from a negedge and counts negedges until MIO_ready (lat = -1 on timeout)
   task automatic xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] data, output int lat);
      @(negedge clk);
      MemRead = rd; MemWrite = wr; addr = a; wdata = d;
      lat = -1; data = 32'hBAD0_BAD0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (MIO_ready) begin
            lat = c; data = rdata;
            break;
         end
      end
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic test_reset();
      total_cnt++; if (MIO_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", MIO_ready); else pass_cnt++;
      total_cnt++; if (rdata !== 32'd0) $display("FAIL reset_rdata got %h want 0", rdata); else pass_cnt++;
      total_cnt++; if (led_out !== 32'd0) $display("FAIL reset_led got %h want 0", led_out); else pass_cnt++;
      total_cnt++; if (bus_err !== 1'b0) $display("FAIL reset_bus_err got %b want 0", bus_err); else pass_cnt++;
   endtask

   task automatic test_ram_rw();
      logic [31:0] d; int lat;
      xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, d, lat);
      total_cnt++; if (lat !== 3) $display("FAIL wr_latency got %0d want 3", lat); else pass_cnt++;
      xfer(1'b1, 1'b0, 32'h10, 32'h0, d, lat);
      total_cnt++; if (lat !== 3) $display("FAIL rd_latency got %0d want 3", lat); else pass_cnt++;
      total_cnt++; if (d !== 32'hDEAD_BEEF) $display("FAIL rd_data got %h want deadbeef", d); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; int lat;
      logic [31:0] exp_d [3];
      logic [31:0] got_d [3];
      int          got_t [3];
      int          k;
      int          extra;
      exp_d[0] = 32'h0A0A_0A0A; exp_d[1] = 32'h1B1B_1B1B; exp_d[2] = 32'h2C2C_2C2C;
      for (int i = 0; i < 3; i++) begin
         xfer(1'b0, 1'b1, 32'(i * 4), exp_d[i], d, lat);
         got_t[i] = -1; got_d[i] = 32'hBAD0_BAD0;
      end
      @(negedge clk);
      MemRead = 1'b1; addr = 32'h0;
      k = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (MIO_ready) begin
            got_t[k] = c; got_d[k] = rdata;
            k++;
            if (k == 3) break;
            addr = 32'(k * 4);
         end
      end
      MemRead = 1'b0;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (MIO_ready) extra++;
      end
      for (int i = 0; i < 3; i++) begin
         total_cnt++; if (got_t[i] !== 3 + 4 * i) $display("FAIL b2b_time%0d got %0d want %0d", i, got_t[i], 3 + 4 * i); else pass_cnt++;
         total_cnt++; if (got_d[i] !== exp_d[i]) $display("FAIL b2b_data%0d got %h want %h", i, got_d[i], exp_d[i]); else pass_cnt++;
      end
      total_cnt++; if (extra !== 0) $display("FAIL b2b_extra_pulses got %0d want 0", extra); else pass_cnt++;
   endtask

   task automatic test_io_regs();
      logic [31:0] d; int lat;
      xfer(1'b0, 1'b1, 32'hE000_0000, 32'h0000_00A5, d, lat);
      total_cnt++; if (led_out !== 32'hA5) $display("FAIL led_write got %h want a5", led_out); else pass_cnt++;
      switches = 32'h1234;
      xfer(1'b1, 1'b0, 32'hE000_0004, 32'h0, d, lat);
      total_cnt++; if (d !== 32'h1234) $display("FAIL switch_read got %h want 1234", d); else pass_cnt++;
      xfer(1'b1, 1'b0, 32'hE000_0000, 32'h0, d, lat);
      total_cnt++; if (d !== 32'hA5) $display("FAIL led_read got %h want a5", d); else pass_cnt++;
      total_cnt++; if (bus_err !== 1'b0) $display("FAIL io_bus_err got %b want 0", bus_err); else pass_cnt++;
   endtask

   task automatic test_cyc_cnt();
      logic [31:0] d; int lat;
      xfer(1'b0, 1'b1, 32'hE000_0008, 32'h1234_5678, d, lat);
      // counter is 0 in the ACK cycle; request driven 3 cycles later is read 2 cycles after that
      repeat (2) @(negedge clk);
      xfer(1'b1, 1'b0, 32'hE000_0008, 32'h0, d, lat);
      total_cnt++; if (d !== 32'd5) $display("FAIL cnt_after_clear got %0d want 5", d); else pass_cnt++;
      total_cnt++; if (bus_err !== 1'b0) $display("FAIL cnt_bus_err got %b want 0", bus_err); else pass_cnt++;
      @(negedge clk);
      force dut.cyc_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.cyc_cnt;
      @(negedge clk);
      total_cnt++; if (dut.cyc_cnt !== 32'd0) $display("FAIL cnt_wrap got %h want 0", dut.cyc_cnt); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if (dut.cyc_cnt !== 32'd1) $display("FAIL cnt_after_wrap got %h want 1", dut.cyc_cnt); else pass_cnt++;
   endtask

   task automatic test_errors();
      logic [31:0] d; int lat;
      pulse_reset();
      xfer(1'b1, 1'b1, 32'h10, 32'h55, d, lat);
      total_cnt++; if (lat !== 3) $display("FAIL both_latency got %0d want 3", lat); else pass_cnt++;
      total_cnt++; if (d !== 32'hDEAD_BEEF) $display("FAIL both_as_read got %h want deadbeef", d); else pass_cnt++;
      total_cnt++; if (bus_err !== 1'b1) $display("FAIL both_bus_err got %b want 1", bus_err); else pass_cnt++;
      xfer(1'b1, 1'b0, 32'h10, 32'h0, d, lat);
      total_cnt++; if (d !== 32'hDEAD_BEEF) $display("FAIL both_no_write got %h want deadbeef", d); else pass_cnt++;
      total_cnt++; if (bus_err !== 1'b1) $display("FAIL bus_err_sticky got %b want 1", bus_err); else pass_cnt++;
      pulse_reset();
      total_cnt++; if (bus_err !== 1'b0) $display("FAIL bus_err_reset got %b want 0", bus_err); else pass_cnt++;
      xfer(1'b1, 1'b0, 32'h3, 32'h0, d, lat);
      total_cnt++; if (d !== 32'h0A0A_0A0A) $display("FAIL misalign_data got %h want 0a0a0a0a", d); else pass_cnt++;
      total_cnt++; if (bus_err !== 1'b1) $display("FAIL misalign_bus_err got %b want 1", bus_err); else pass_cnt++;
      pulse_reset();
      xfer(1'b0, 1'b1, 32'hE000_000C, 32'h77, d, lat);
      total_cnt++; if (lat !== 3) $display("FAIL unmapped_latency got %0d want 3", lat); else pass_cnt++;
      total_cnt++; if (bus_err !== 1'b1) $display("FAIL unmapped_bus_err got %b want 1", bus_err); else pass_cnt++;
      xfer(1'b1, 1'b0, 32'hE000_000C, 32'h0, d, lat);
      total_cnt++; if (d !== 32'd0) $display("FAIL unmapped_read got %h want 0", d); else pass_cnt++;
      pulse_reset();
      xfer(1'b0, 1'b1, 32'hE000_0000, 32'h3C, d, lat);
      total_cnt++; if (bus_err !== 1'b0) $display("FAIL led_wr_bus_err got %b want 0", bus_err); else pass_cnt++;
      xfer(1'b0, 1'b1, 32'hE000_0004, 32'hFF, d, lat);
      total_cnt++; if (lat !== 3) $display("FAIL ro_wr_latency got %0d want 3", lat); else pass_cnt++;
      total_cnt++; if (bus_err !== 1'b1) $display("FAIL ro_wr_bus_err got %b want 1", bus_err); else pass_cnt++;
      total_cnt++; if (led_out !== 32'h3C) $display("FAIL ro_wr_led got %h want 3c", led_out); else pass_cnt++;
   endtask

   task automatic test_reset_mid_transfer();
      logic [31:0] d; int lat;
      int pulses;
      pulse_reset();
      xfer(1'b0, 1'b1, 32'h20, 32'h1111_1111, d, lat);
      @(negedge clk);
      MemWrite = 1'b1; addr = 32'h20; wdata = 32'hCAFE_F00D;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1; MemWrite = 1'b0;
      pulses = 0;
      @(negedge clk);
      if (MIO_ready) pulses++;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (MIO_ready) pulses++;
      end
      total_cnt++; if (pulses !== 0) $display("FAIL abort_pulses got %0d want 0", pulses); else pass_cnt++;
      total_cnt++; if (led_out !== 32'd0) $display("FAIL abort_led got %h want 0", led_out); else pass_cnt++;
      xfer(1'b1, 1'b0, 32'h20, 32'h0, d, lat);
      total_cnt++; if (lat !== 3) $display("FAIL post_reset_latency got %0d want 3", lat); else pass_cnt++;
      total_cnt++; if (d !== 32'h1111_1111) $display("FAIL abort_ram got %h want 11111111", d); else pass_cnt++;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_ram_rw();
      test_back_to_back();
      test_io_regs();
      test_cyc_cnt();
      test_errors();
      test_reset_mid_transfer();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
